// File: rtl/cache_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// cache_axi_rd_arbiter
//
// Shares a single AXI4 read channel (AR/R) between NUM_REQ L1-cache read
// requesters (ICache refill, ICache uncached, DCache refill, DCache uncached).
// One requester is granted at a time, one AR burst is issued, R beats are
// assembled into a line buffer and the line is returned with a single
// ret_valid pulse. Only one transaction is ever outstanding.
//
// Build option:
//   RD_ARB_FIXED_PRIO_EN  defined     -> fixed priority, lowest index wins
//                         not defined -> round-robin starting at rr_ptr
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   req_rd_req           per-requester read request (held until its rd_rdy)
//   req_rd_addr          per-requester byte address, slice i = [32*i+31:32*i]
//   req_is_line          1 = line burst, 0 = single word
//   req_rd_rdy           one-hot 1-cycle grant pulse
//   req_ret_valid        one-hot 1-cycle data-return pulse
//   req_ret_data         shared line buffer, word k = [32*k+31:32*k]
//   arid..arvalid,arready AXI AR channel (master side)
//   rid..rvalid,rready    AXI R channel (master side); rid/rresp ignored
// -----------------------------------------------------------------------------
module cache_axi_rd_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int LINE_WORD_NUM = 4,
  parameter int ID_WIDTH      = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_rd_req,
  input  logic [NUM_REQ*32-1:0]         req_rd_addr,
  input  logic [NUM_REQ-1:0]            req_is_line,
  output logic [NUM_REQ-1:0]            req_rd_rdy,
  output logic [NUM_REQ-1:0]            req_ret_valid,
  output logic [LINE_WORD_NUM*32-1:0]   req_ret_data,
  output logic [ID_WIDTH-1:0]           arid,
  output logic [31:0]                   araddr,
  output logic [7:0]                    arlen,
  output logic [2:0]                    arsize,
  output logic [1:0]                    arburst,
  output logic                          arvalid,
  input  logic                          arready,
  input  logic [ID_WIDTH-1:0]           rid,
  input  logic [31:0]                   rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rlast,
  input  logic                          rvalid,
  output logic                          rready
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BEAT_W = (LINE_WORD_NUM > 1) ? $clog2(LINE_WORD_NUM) : 1;
  // Clears the byte offset within a line so line bursts start aligned.
  localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORD_NUM * 4 - 1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                        state;
  state_t                        state_nxt;

  logic                          any_req;
  logic [IDX_W-1:0]              win_idx;
  logic                          grant;
  logic [31:0]                   grant_addr;
  logic                          grant_line;

  logic [IDX_W-1:0]              gnt_id;
  logic [31:0]                   araddr_r;
  logic [7:0]                    arlen_r;
  logic [NUM_REQ-1:0]            rd_rdy_r;
  logic [LINE_WORD_NUM*32-1:0]   ret_data_r;
  logic [BEAT_W-1:0]             beat_cnt;
  // Set once the last line word is written so surplus beats cannot
  // overwrite it while beat_cnt sits saturated.
  logic                          beat_full;

  // rid/rresp are deliberately not checked.
  logic                          unused_r;
  assign unused_r = ^{rid, rresp};

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef RD_ARB_FIXED_PRIO_EN
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_req && req_rd_req[k]) begin
        any_req = 1'b1;
        win_idx = IDX_W'(k);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] cand;

  // Scan requesters starting at rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!any_req && req_rd_req[cand]) begin
        any_req = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr <= '0;
    end else if (grant) begin
      if (win_idx == IDX_W'(NUM_REQ - 1)) rr_ptr <= '0;
      else                                rr_ptr <= win_idx + IDX_W'(1);
    end
  end
`endif

  assign grant      = (state == S_IDLE) && any_req;
  assign grant_addr = req_rd_addr[32*win_idx +: 32];
  assign grant_line = req_is_line[win_idx];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req)          state_nxt = S_AR;
      S_AR:    if (arready)          state_nxt = S_R;
      S_R:     if (rvalid && rlast)  state_nxt = S_DONE;
      S_DONE:                        state_nxt = S_IDLE;
      default:                       state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Grant capture and line assembly
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gnt_id     <= '0;
      araddr_r   <= '0;
      arlen_r    <= '0;
      rd_rdy_r   <= '0;
      ret_data_r <= '0;
      beat_cnt   <= '0;
      beat_full  <= 1'b0;
    end else begin
      rd_rdy_r <= '0;
      if (grant) begin
        rd_rdy_r   <= NUM_REQ'(1) << win_idx;
        gnt_id     <= win_idx;
        araddr_r   <= grant_line ? (grant_addr & LINE_MASK) : grant_addr;
        arlen_r    <= grant_line ? 8'(LINE_WORD_NUM - 1) : 8'd0;
        ret_data_r <= '0;
        beat_cnt   <= '0;
        beat_full  <= 1'b0;
      end else if (state == S_R && rvalid && !beat_full) begin
        ret_data_r[32*beat_cnt +: 32] <= rdata;
        if (beat_cnt == BEAT_W'(LINE_WORD_NUM - 1)) beat_full <= 1'b1;
        else                                        beat_cnt  <= beat_cnt + BEAT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: AR fields are held at zero outside the AR state so the whole
  // bus reads zero in reset and while idle.
  // ---------------------------------------------------------------------------
  assign arvalid       = (state == S_AR);
  assign arid          = arvalid ? ID_WIDTH'(gnt_id) : '0;
  assign araddr        = arvalid ? araddr_r : '0;
  assign arlen         = arvalid ? arlen_r : '0;
  assign arsize        = arvalid ? 3'b010 : 3'b000;
  assign arburst       = arvalid ? 2'b01 : 2'b00;
  assign rready        = (state == S_R);
  assign req_rd_rdy    = rd_rdy_r;
  assign req_ret_valid = (state == S_DONE) ? (NUM_REQ'(1) << gnt_id) : '0;
  assign req_ret_data  = ret_data_r;

endmodule
